melody_sequencer: RTL and testbench

- Memory-mapped score player that sits directly upstream of the buzzer peripheral.
- Holds a 64-entry score RAM of {note code, duration ms}. On each note it issues one load strobe carrying a note code and a ms duration to the buzzer.
- Waits for the buzzer to finish the note, then inserts an optional inter-note gap and steps to the next entry.
- Supports single-shot and looped playback, stop, and status readback over the same bus style as the other peripherals.

---
 rtl/melody_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_melody_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// Score player: bus-programmed note RAM feeding one load strobe per note to the buzzer.
// Optional macro MELODY_TEMPO_SCALE_EN adds TEMPO register 4 that scales note durations.
module melody_sequencer #(
   parameter int MS_CYCLES  = 50000,
   parameter int DEPTH_LOG2 = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  addrIn,
   input  logic [7:0]  addrOut,
   input  logic [3:0]  sizeDecode,
   input  logic [31:0] dataIn,
   output logic [31:0] dataOut,
   input  logic        noteBusy,
   output logic        noteLoad,
   output logic [3:0]  noteOut,
   output logic [15:0] timeOut
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LW    = DEPTH_LOG2 + 1;
   localparam int PW    = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_ACK, S_PLAY, S_GAP, S_NEXT, S_END
   } state_t;

   state_t                r_state;
   logic [DEPTH_LOG2-1:0] r_idx;
   logic                  r_done;
   logic                  r_loop;
   logic [LW-1:0]         r_len;
   logic [15:0]           r_gap;
   logic [15:0]           r_gap_cnt;
   logic [PW-1:0]         r_pre;
   logic                  r_note_load;
   logic [3:0]            r_note;
   logic [15:0]           r_time;
   logic [31:0]           r_dout;
   logic [19:0]           r_ram [DEPTH];
   logic [19:0]           r_entry;

   logic                  w_reg_wr;
   logic                  w_ram_wr;
   logic                  w_ctrl_lo;
   logic                  w_start;
   logic                  w_stop;
   logic [LW-1:0]         w_len_wr;
   logic [19:0]           w_rd;
   logic [15:0]           w_load_time;
   logic [31:0]           w_stat;
   logic [31:0]           w_rdata;
   logic                  w_unused;

   assign w_reg_wr  = !addrIn[7] && (sizeDecode != 4'b0000);
   assign w_ram_wr  = addrIn[7] && (sizeDecode == 4'b1111);
   assign w_ctrl_lo = w_reg_wr && (addrIn[2:0] == 3'd0) && sizeDecode[0];
   assign w_start   = w_ctrl_lo && dataIn[0];
   assign w_stop    = w_ctrl_lo && dataIn[1];
   assign w_len_wr  = (dataIn[LW-1:0] > LW'(DEPTH)) ? LW'(DEPTH) : dataIn[LW-1:0];
   assign w_rd      = r_ram[r_idx];
   assign w_unused  = ^{dataIn[31:20], addrIn[6], addrOut[6:3]};

`ifdef MELODY_TEMPO_SCALE_EN
   logic [7:0]  r_tempo;
   logic [15:0] r_scaled;
   logic [7:0]  w_tempo;
   logic [23:0] w_prod;

   // TEMPO is a 4.4 fixed-point factor; 0 behaves as unity
   assign w_tempo     = (r_tempo == 8'd0) ? 8'd16 : r_tempo;
   assign w_prod      = 24'(w_rd[15:0]) * 24'(w_tempo);
   assign w_load_time = r_scaled;

   always_ff @(posedge clk) begin
      if (r_state == S_FETCH) begin
         r_scaled <= (w_prod[23:20] != 4'd0) ? 16'hFFFF : w_prod[19:4];
      end
   end
`else
   assign w_load_time = r_entry[15:0];
`endif

   // Score RAM is deliberately not reset so a score survives a reset
   always_ff @(posedge clk) begin
      if (w_ram_wr) begin
         r_ram[addrIn[DEPTH_LOG2-1:0]] <= dataIn[19:0];
      end
      if (r_state == S_FETCH) begin
         r_entry <= w_rd;
      end
   end

   always_comb begin
      w_stat = '0;
      w_stat[0] = (r_state != S_IDLE);
      w_stat[1] = (r_state == S_GAP);
      w_stat[8 +: DEPTH_LOG2] = r_idx;
      w_stat[16] = r_done;
   end

   always_comb begin
      w_rdata = '0;
      if (!addrOut[7]) begin
         case (addrOut[2:0])
            3'd0: w_rdata[2] = r_loop;
            3'd1: w_rdata[LW-1:0] = r_len;
            3'd2: w_rdata[15:0] = r_gap;
            3'd3: w_rdata = w_stat;
`ifdef MELODY_TEMPO_SCALE_EN
            3'd4: w_rdata[7:0] = r_tempo;
`endif
            default: w_rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_done      <= 1'b0;
         r_loop      <= 1'b0;
         r_len       <= '0;
         r_gap       <= '0;
         r_gap_cnt   <= '0;
         r_pre       <= '0;
         r_note_load <= 1'b0;
         r_note      <= '0;
         r_time      <= '0;
         r_dout      <= '0;
`ifdef MELODY_TEMPO_SCALE_EN
         r_tempo     <= 8'd16;
`endif
      end else begin
         r_note_load <= 1'b0;
         r_dout      <= w_rdata;
         if (w_reg_wr) begin
            case (addrIn[2:0])
               3'd0: if (sizeDecode[0]) r_loop <= dataIn[2];
               3'd1: if (sizeDecode[0]) r_len <= w_len_wr;
               3'd2: begin
                  if (sizeDecode[0]) r_gap[7:0]  <= dataIn[7:0];
                  if (sizeDecode[1]) r_gap[15:8] <= dataIn[15:8];
               end
`ifdef MELODY_TEMPO_SCALE_EN
               3'd4: if (sizeDecode[0]) r_tempo <= dataIn[7:0];
`endif
               default: ;
            endcase
         end
         // STOP wins over START and every state; a running note is silenced with a 0/0 load
         if (w_stop) begin
            r_state <= S_IDLE;
            if (r_state != S_IDLE) begin
               r_note_load <= 1'b1;
               r_note      <= '0;
               r_time      <= '0;
            end
         end else begin
            case (r_state)
               S_IDLE: if (w_start) begin
                  if (r_len != '0) begin
                     r_state <= S_FETCH;
                     r_idx   <= '0;
                     r_done  <= 1'b0;
                  end else begin
                     r_done  <= 1'b1;
                  end
               end
               S_FETCH: r_state <= S_LOAD;
               S_LOAD: begin
                  if (r_entry[15:0] == 16'd0) begin
                     r_state <= S_END;
                  end else begin
                     r_note      <= r_entry[19:16];
                     r_time      <= w_load_time;
                     r_note_load <= 1'b1;
                     r_state     <= S_ACK;
                  end
               end
               S_ACK: r_state <= S_PLAY;
               S_PLAY: if (!noteBusy) begin
                  if (r_gap != 16'd0) begin
                     r_state   <= S_GAP;
                     r_gap_cnt <= r_gap;
                     r_pre     <= '0;
                  end else begin
                     r_state   <= S_NEXT;
                  end
               end
               S_GAP: begin
                  if (r_pre == PW'(MS_CYCLES - 1)) begin
                     r_pre     <= '0;
                     r_gap_cnt <= r_gap_cnt - 16'd1;
                     if (r_gap_cnt == 16'd1) r_state <= S_NEXT;
                  end else begin
                     r_pre <= r_pre + PW'(1);
                  end
               end
               S_NEXT: begin
                  if (LW'(r_idx) + LW'(1) >= r_len) begin
                     r_state <= S_END;
                  end else begin
                     r_idx   <= r_idx + DEPTH_LOG2'(1);
                     r_state <= S_FETCH;
                  end
               end
               S_END: begin
                  if (r_loop) begin
                     r_idx   <= '0;
                     r_state <= S_FETCH;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign dataOut  = r_dout;
   assign noteLoad = r_note_load;
   assign noteOut  = r_note;
   assign timeOut  = r_time;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a buzzer model and a load scoreboard.
module tb_melody_sequencer;

   localparam int MS = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  addrIn;
   logic [7:0]  addrOut;
   logic [3:0]  sizeDecode;
   logic [31:0] dataIn;
   logic [31:0] dataOut;
   logic        noteBusy;
   logic        noteLoad;
   logic [3:0]  noteOut;
   logic [15:0] timeOut;

   always #5 clk = ~clk;

   melody_sequencer #(.MS_CYCLES(MS), .DEPTH_LOG2(6)) dut (
      .clk(clk), .rst(rst), .addrIn(addrIn), .addrOut(addrOut),
      .sizeDecode(sizeDecode), .dataIn(dataIn), .dataOut(dataOut),
      .noteBusy(noteBusy), .noteLoad(noteLoad), .noteOut(noteOut), .timeOut(timeOut)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Buzzer: busy for timeOut ms starting the cycle after the load strobe
   int bz_cnt = 0;
   always @(posedge clk or posedge rst) begin
      if (rst) bz_cnt <= 0;
      else if (noteLoad) bz_cnt <= int'(timeOut) * MS;
      else if (bz_cnt != 0) bz_cnt <= bz_cnt - 1;
   end
   assign noteBusy = (bz_cnt != 0);

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   logic [19:0] exp_q[$];
   int          t_load[$];
   int          n_loads = 0;
   int          n_exp = 0;
   int          wr_cyc = 0;

   always @(negedge clk) begin
      if (!rst && noteLoad) begin
         n_loads++;
         t_load.push_back(cyc);
         if (exp_q.size() == 0) check("load_count", 32'(n_loads), 32'(n_exp));
         else check("load", {12'h0, noteOut, timeOut}, {12'h0, exp_q.pop_front()});
      end
   end

   task automatic expect_load(input logic [3:0] n, input logic [15:0] t);
      exp_q.push_back({n, t});
      n_exp++;
   endtask

   task automatic new_test();
      @(negedge clk); #1;
      n_loads = 0;
      n_exp = 0;
      t_load.delete();
      exp_q.delete();
   endtask

   task automatic end_test(input string tag);
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      addrIn = a; dataIn = d; sizeDecode = s; wr_cyc = cyc;
      @(negedge clk);
      sizeDecode = 4'h0;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
      @(negedge clk);
      addrOut = a;
      @(negedge clk);
      d = dataOut;
   endtask

   task automatic wr_entry(input int i, input logic [3:0] n, input logic [15:0] t);
      bus_write(8'h80 | 8'(i), {12'h0, n, t}, 4'hF);
   endtask

   task automatic wait_loads(input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (n_loads < n && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      check(tag, 32'(n_loads), 32'(n));
   endtask

   task automatic wait_idle(input int budget, input string tag, output logic [31:0] st);
      int k;
      k = 0;
      bus_read(8'h03, st);
      while (st[0] && k < budget) begin
         bus_read(8'h03, st);
         k++;
      end
      check(tag, 32'(st[0]), 32'd0);
   endtask

   function automatic int t_at(input int i);
      return (t_load.size() > i) ? t_load[i] : -100000;
   endfunction

   initial begin
      #800000;
      $display("FAIL watchdog cycles=%0d", cyc);
      $fatal(1, "watchdog");
   end

   logic [31:0] rd;
   int          s0, fall, gapc, k;
   logic        was_busy;

   initial begin
      rst = 1'b1; addrIn = '0; addrOut = '0; sizeDecode = '0; dataIn = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_dataOut", dataOut, 32'd0);
      check("rst_noteLoad", 32'(noteLoad), 32'd0);
      check("rst_note_time", {12'h0, noteOut, timeOut}, 32'd0);
      rst = 1'b0;
      bus_read(8'h03, rd); check("rst_stat", rd, 32'd0);
      bus_read(8'h01, rd); check("rst_len", rd, 32'd0);
`ifdef MELODY_TEMPO_SCALE_EN
      bus_read(8'h04, rd); check("rst_tempo", rd, 32'd16);
`endif

      // register rules
      bus_write(8'h01, 32'd100, 4'hF); bus_read(8'h01, rd); check("len_clamp", rd, 32'd64);
      bus_write(8'h01, 32'd50, 4'hF);  bus_read(8'h01, rd); check("len_plain", rd, 32'd50);
      bus_write(8'h02, 32'h1234, 4'b0001); bus_read(8'h02, rd); check("gap_lane0", rd, 32'h34);
      bus_write(8'h00, 32'h4, 4'hF); bus_read(8'h00, rd); check("ctrl_loop_set", rd, 32'h4);
      bus_write(8'h00, 32'h0, 4'hF); bus_read(8'h00, rd); check("ctrl_loop_clr", rd, 32'h0);
      bus_write(8'h05, 32'hFFFF_FFFF, 4'hF); bus_read(8'h05, rd); check("unmapped_rd", rd, 32'd0);
`ifndef MELODY_TEMPO_SCALE_EN
      bus_write(8'h04, 32'hFF, 4'hF); bus_read(8'h04, rd); check("reg4_absent", rd, 32'd0);
`endif
      wr_entry(0, 4'd1, 16'd100);
      bus_read(8'h80, rd); check("score_rd_zero", rd, 32'd0);

      // basic three-note score
      wr_entry(1, 4'd5, 16'd50);
      wr_entry(2, 4'd8, 16'd20);
      bus_write(8'h01, 32'd3, 4'hF);
      bus_write(8'h02, 32'd0, 4'hF);
      new_test();
      expect_load(4'd1, 16'd100); expect_load(4'd5, 16'd50); expect_load(4'd8, 16'd20);
      bus_write(8'h00, 32'h1, 4'hF); s0 = wr_cyc;
      wait_loads(3, 4000, "basic_nloads");
      check("basic_latency", 32'(t_at(0) - s0), 32'd3);
      wait_idle(500, "basic_idle", rd);
      check("basic_stat", rd, 32'h0001_0200);
      bus_read(8'h00, rd); check("ctrl_start_rd0", rd, 32'd0);
      end_test("basic_left");

      // inter-note gap of 2 ms
      bus_write(8'h02, 32'd2, 4'hF);
      new_test();
      expect_load(4'd1, 16'd100); expect_load(4'd5, 16'd50); expect_load(4'd8, 16'd20);
      bus_write(8'h00, 32'h1, 4'hF);
      wait_loads(1, 20, "gap_first");
      addrOut = 8'h03;
      was_busy = 1'b0; fall = -1; gapc = 0; k = 0;
      while (n_loads < 2 && k < 3000) begin
         @(negedge clk); #1;
         k++;
         if (noteBusy) was_busy = 1'b1;
         else if (was_busy && fall < 0) fall = cyc;
         if (dataOut[1]) gapc++;
      end
      check("gap_cycles", 32'(gapc), 32'd20);
      // 20 gap + NEXT + FETCH + LOAD, plus the PLAY cycle that sees noteBusy low
      check("gap_fall_to_load", 32'(t_at(1) - fall), 32'd24);
      wait_loads(3, 3000, "gap_nloads");
      wait_idle(500, "gap_idle", rd);
      check("gap_stat", rd, 32'h0001_0200);
      end_test("gap_left");
      bus_write(8'h02, 32'd0, 4'hF);

      // looped playback, then STOP mid-note
      wr_entry(0, 4'd3, 16'd4);
      wr_entry(1, 4'd9, 16'd2);
      bus_write(8'h01, 32'd2, 4'hF);
      new_test();
      expect_load(4'd3, 16'd4); expect_load(4'd9, 16'd2);
      expect_load(4'd3, 16'd4); expect_load(4'd9, 16'd2);
      expect_load(4'd3, 16'd4); expect_load(4'd0, 16'd0);
      bus_write(8'h00, 32'h5, 4'hF);
      wait_loads(5, 2000, "loop_nloads");
      repeat (5) @(negedge clk);
      bus_write(8'h00, 32'h6, 4'hF); s0 = wr_cyc;
      wait_loads(6, 20, "stop_nloads");
      check("stop_latency", 32'(t_at(5) - s0), 32'd1);
      bus_read(8'h03, rd); check("stop_stat", rd, 32'd0);
      bus_read(8'h00, rd); check("stop_loop_kept", rd, 32'h4);
      end_test("loop_left");
      bus_write(8'h00, 32'h0, 4'hF);

      // START with LEN=0
      bus_write(8'h01, 32'd0, 4'hF);
      new_test();
      bus_write(8'h00, 32'h1, 4'hF);
      repeat (10) @(negedge clk);
      check("len0_nloads", 32'(n_loads), 32'd0);
      bus_read(8'h03, rd); check("len0_stat", rd, 32'h0001_0000);

      // START and STOP together from IDLE
      bus_write(8'h01, 32'd3, 4'hF);
      new_test();
      bus_write(8'h00, 32'h3, 4'hF);
      repeat (10) @(negedge clk);
      check("startstop_nloads", 32'(n_loads), 32'd0);
      bus_read(8'h03, rd); check("startstop_stat", rd, 32'h0001_0000);

      // end marker, with a dropped partial write on entry 0
      wr_entry(0, 4'd2, 16'd3);
      bus_write(8'h80, 32'h0007_0007, 4'b0011);
      wr_entry(1, 4'd4, 16'd0);
      wr_entry(2, 4'd6, 16'd5);
      new_test();
      expect_load(4'd2, 16'd3);
      bus_write(8'h00, 32'h1, 4'hF);
      wait_loads(1, 20, "endmk_first");
      bus_read(8'h03, rd); check("endmk_busy_stat", rd, 32'h0000_0001);
      wait_idle(500, "endmk_idle", rd);
      check("endmk_stat", rd, 32'h0001_0100);
      check("endmk_nloads", 32'(n_loads), 32'd1);
      end_test("endmk_left");

`ifdef MELODY_TEMPO_SCALE_EN
      bus_write(8'h04, 32'd32, 4'hF); bus_read(8'h04, rd); check("tempo_rd", rd, 32'd32);
      wr_entry(0, 4'd1, 16'd100);
      bus_write(8'h01, 32'd1, 4'hF);
      new_test();
      expect_load(4'd1, 16'd200); expect_load(4'd0, 16'd0);
      bus_write(8'h00, 32'h1, 4'hF);
      wait_loads(1, 20, "tempo32_load");
      bus_write(8'h00, 32'h2, 4'hF);
      wait_loads(2, 20, "tempo32_stop");
      end_test("tempo32_left");
      bus_write(8'h04, 32'd255, 4'hF);
      wr_entry(0, 4'd2, 16'h8000);
      new_test();
      expect_load(4'd2, 16'hFFFF); expect_load(4'd0, 16'd0);
      bus_write(8'h00, 32'h1, 4'hF);
      wait_loads(1, 20, "tempo255_load");
      bus_write(8'h00, 32'h2, 4'hF);
      wait_loads(2, 20, "tempo255_stop");
      end_test("tempo255_left");
      bus_write(8'h04, 32'd0, 4'hF);
      wr_entry(0, 4'd5, 16'd7);
      new_test();
      expect_load(4'd5, 16'd7); expect_load(4'd0, 16'd0);
      bus_write(8'h00, 32'h1, 4'hF);
      wait_loads(1, 20, "tempo0_load");
      bus_write(8'h00, 32'h2, 4'hF);
      wait_loads(2, 20, "tempo0_stop");
      end_test("tempo0_left");
      bus_write(8'h04, 32'd16, 4'hF);
`endif

      // asynchronous reset mid-note, then replay from retained RAM
      wr_entry(0, 4'd3, 16'd10);
      bus_write(8'h01, 32'd1, 4'hF);
      new_test();
      expect_load(4'd3, 16'd10);
      bus_write(8'h00, 32'h1, 4'hF);
      wait_loads(1, 20, "rstmid_load");
      addrOut = 8'h03;
      repeat (10) @(negedge clk);
      check("rstmid_pre_stat", dataOut, 32'h0000_0001);
      #2 rst = 1'b1;
      #1;
      check("rstmid_noteLoad", 32'(noteLoad), 32'd0);
      check("rstmid_note_time", {12'h0, noteOut, timeOut}, 32'd0);
      check("rstmid_dataOut", dataOut, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus_read(8'h01, rd); check("rstmid_len", rd, 32'd0);
      bus_write(8'h01, 32'd1, 4'hF);
      new_test();
      expect_load(4'd3, 16'd10);
      bus_write(8'h00, 32'h1, 4'hF); s0 = wr_cyc;
      wait_loads(1, 20, "replay_load");
      check("replay_latency", 32'(t_at(0) - s0), 32'd3);
      wait_idle(500, "replay_idle", rd);
      check("replay_stat", rd, 32'h0001_0000);
      end_test("replay_left");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
